// File: rtl/stopwatch_seq_pkg.sv
// Shared definitions for the stopwatch sequencer, its datapath and benches.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package stopwatch_seq_pkg;

    // Sequencer state encoding; the datapath decodes these values directly.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_SPLIT = 2'd3
    } sw_state_e;

    localparam int DEF_TICK_DIV  = 4;
    localparam int DEF_LAP_DEPTH = 4;

endpackage

// File: rtl/stopwatch_seq_tick_prescaler.sv
// Divides clk down to a one-cycle count tick every TICK_DIV enabled cycles.
// Latency: tick is a decode of the phase register, high in the last enabled cycle of each period.
// Backpressure: none; holding en low freezes the phase, clr forces it back to zero.
//
// Ports:
//   clk, reset : system clock, synchronous active-low reset
//   en         : advance the phase this cycle (counting active)
//   clr        : force the phase to zero (sequencer idle)
//   tick       : one-cycle count-advance pulse
module tick_prescaler #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] phase_q;
    logic [PW-1:0] phase_d;

    always_comb begin
        phase_d = phase_q;
        if (clr) begin
            phase_d = '0;
        end else if (en) begin
            phase_d = (phase_q == LAST) ? '0 : phase_q + PW'(1);
        end
    end

    // Phase only moves while enabled, so a pause keeps the partial period.
    assign tick = en && !clr && (phase_q == LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/stopwatch_seq.sv
// Stopwatch sequencer: start/stop/split FSM, lap buffer pointer, overflow flag and tick prescaler.
// Latency: a trig/split pulse sampled at an edge changes the outputs right after that edge.
// Backpressure: none; a split against a full lap buffer sets the sticky lap_ovf instead of writing.
//
// Ports:
//   clk, reset      : system clock, synchronous active-low reset
//   trig, split     : debounced one-cycle start/stop and split/clear pulses
//   init_regs       : hold datapath counters at zero (idle)
//   count_enabled   : counting active (run or split)
//   tick            : one-cycle count-advance pulse
//   freeze_display  : show the latched lap value instead of the live count
//   lap_wr_en/addr  : one-cycle lap memory write strobe and its address
//   lap_count/full  : laps stored, buffer full
//   lap_ovf         : sticky, split attempted while full
module stopwatch_seq
    import stopwatch_seq_pkg::*;
#(
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int LAP_DEPTH = DEF_LAP_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         trig,
    input  logic                         split,
    output logic                         init_regs,
    output logic                         count_enabled,
    output logic                         tick,
    output logic                         freeze_display,
    output logic                         lap_wr_en,
    output logic [$clog2(LAP_DEPTH)-1:0] lap_wr_addr,
    output logic [$clog2(LAP_DEPTH):0]   lap_count,
    output logic                         lap_full,
    output logic                         lap_ovf
);

    localparam int AW = $clog2(LAP_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(LAP_DEPTH);

    sw_state_e     state_q, state_d;
    logic          lap_wr_en_q, lap_wr_en_d;
    logic [AW-1:0] lap_wr_addr_q, lap_wr_addr_d;
    logic [CW-1:0] lap_count_q, lap_count_d;
    logic          lap_ovf_q, lap_ovf_d;

    logic          capture;
    logic          ovf_set;
    logic          clear_laps;

    assign lap_full = (lap_count_q == FULL_CNT);

    // Next-state logic; trig is tested first everywhere so it wins over split.
    always_comb begin
        state_d    = state_q;
        capture    = 1'b0;
        ovf_set    = 1'b0;
        clear_laps = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trig) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (trig) begin
                    state_d = ST_PAUSE;
                end else if (split) begin
                    state_d = ST_SPLIT;
                    // A full buffer still freezes the display; the lap is lost.
                    if (lap_full) ovf_set = 1'b1;
                    else          capture = 1'b1;
                end
            end
            ST_SPLIT: begin
                if (trig)       state_d = ST_PAUSE;
                else if (split) state_d = ST_RUN;
            end
            ST_PAUSE: begin
                if (trig) begin
                    state_d = ST_RUN;
                end else if (split) begin
                    state_d    = ST_IDLE;
                    clear_laps = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Lap pointer: the write goes to the pre-increment count, so the address
    // can never exceed LAP_DEPTH-1 while writes are blocked when full.
    always_comb begin
        lap_wr_en_d   = capture;
        lap_wr_addr_d = lap_wr_addr_q;
        lap_count_d   = lap_count_q;
        lap_ovf_d     = lap_ovf_q | ovf_set;
        if (clear_laps) begin
            lap_wr_addr_d = '0;
            lap_count_d   = '0;
            lap_ovf_d     = 1'b0;
        end else if (capture) begin
            lap_wr_addr_d = lap_count_q[AW-1:0];
            lap_count_d   = lap_count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            lap_wr_en_q   <= 1'b0;
            lap_wr_addr_q <= '0;
            lap_count_q   <= '0;
            lap_ovf_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            lap_wr_en_q   <= lap_wr_en_d;
            lap_wr_addr_q <= lap_wr_addr_d;
            lap_count_q   <= lap_count_d;
            lap_ovf_q     <= lap_ovf_d;
        end
    end

    assign init_regs      = (state_q == ST_IDLE);
    assign count_enabled  = (state_q == ST_RUN) || (state_q == ST_SPLIT);
    assign freeze_display = (state_q == ST_SPLIT);
    assign lap_wr_en      = lap_wr_en_q;
    assign lap_wr_addr    = lap_wr_addr_q;
    assign lap_count      = lap_count_q;
    assign lap_ovf        = lap_ovf_q;

    // Phase is cleared while idle so every fresh start gets a full first period.
    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (count_enabled),
        .clr   (init_regs),
        .tick  (tick)
    );

endmodule
